// File: rtl/two_bit_bpu_if.sv
// -----------------------------------------------------------------------------
// two_bit_bpu_if
// Bundles the fetch-side lookup, EX-side training and perf-counter signals of
// the branch prediction unit. Signal names keep the i_/o_ prefixes as seen
// from the BPU itself, so i_* are driven by the core and o_* by the BPU.
//   master : core side (IF + EX stages, perf readers)
//   slave  : two_bit_bpu
// -----------------------------------------------------------------------------
interface two_bit_bpu_if;

    // Lookup path (IF stage)
    logic [31:0] i_if_pc;
    logic        o_pred_hit;
    logic        o_pred_taken;
    logic [31:0] o_pred_next_pc;

    // Training path (EX stage)
    logic        i_ex_upd_vld;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_mispred;

    // Performance counters (all zero unless BPU_PERF_EN is defined)
    logic [31:0] o_perf_br_cnt;
    logic [31:0] o_perf_mispred_cnt;

    modport master (
        output i_if_pc,
        output i_ex_upd_vld,
        output i_ex_pc,
        output i_ex_taken,
        output i_ex_target,
        output i_ex_mispred,
        input  o_pred_hit,
        input  o_pred_taken,
        input  o_pred_next_pc,
        input  o_perf_br_cnt,
        input  o_perf_mispred_cnt
    );

    modport slave (
        input  i_if_pc,
        input  i_ex_upd_vld,
        input  i_ex_pc,
        input  i_ex_taken,
        input  i_ex_target,
        input  i_ex_mispred,
        output o_pred_hit,
        output o_pred_taken,
        output o_pred_next_pc,
        output o_perf_br_cnt,
        output o_perf_mispred_cnt
    );

endinterface : two_bit_bpu_if

// File: rtl/two_bit_bpu.sv
// -----------------------------------------------------------------------------
// two_bit_bpu
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry. Lookup is purely combinational on the IF PC; training from the EX
// stage writes the table on the rising edge (single write port, no bypass, so
// a same-cycle lookup sees the pre-update entry).
//
// Optional feature macro:
//   BPU_PERF_EN - adds saturating resolved-branch and mispredict counters.
//                 When undefined, no counter registers exist and both perf
//                 outputs are tied to zero.
//
// Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
// -----------------------------------------------------------------------------
module two_bit_bpu #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    two_bit_bpu_if.slave     bus
);

    localparam int DEPTH  = 1 << INDEX_W;
    localparam int TAG_LO = INDEX_W + 2;
    localparam int TAG_HI = INDEX_W + TAG_W + 1;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // One BTB entry; the target is word aligned so its low two bits are not stored.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [29:0]      target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t btb_q [DEPTH];

    // ------------------------------------------------------------------
    // Address decomposition
    // ------------------------------------------------------------------
    logic [INDEX_W-1:0] if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   ex_tag;

    assign if_idx = bus.i_if_pc[INDEX_W+1:2];
    assign if_tag = bus.i_if_pc[TAG_HI:TAG_LO];
    assign ex_idx = bus.i_ex_pc[INDEX_W+1:2];
    assign ex_tag = bus.i_ex_pc[TAG_HI:TAG_LO];

    // ------------------------------------------------------------------
    // Lookup (IF stage, zero latency)
    // ------------------------------------------------------------------
    entry_t rd_entry;
    logic   rd_hit;
    logic   rd_taken;

    assign rd_entry = btb_q[if_idx];
    assign rd_hit   = rd_entry.valid && (rd_entry.tag == if_tag);
    assign rd_taken = rd_hit && rd_entry.ctr[1];

    // Predict the stored target on a taken hit, otherwise fall through (wraps at 2^32).
    always_comb begin
        bus.o_pred_hit     = rd_hit;
        bus.o_pred_taken   = rd_taken;
        bus.o_pred_next_pc = bus.i_if_pc + 32'd4;
        if (rd_taken) begin
            bus.o_pred_next_pc = {rd_entry.target, 2'b00};
        end
    end

    // ------------------------------------------------------------------
    // Training (EX stage)
    // ------------------------------------------------------------------
    entry_t ex_entry;
    logic   ex_hit;
    logic   wr_en;
    entry_t wr_entry;

    assign ex_entry = btb_q[ex_idx];
    assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

    // Build the replacement entry: train the counter on a hit, allocate on a taken miss.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        wr_en    = 1'b0;
        wr_entry = ex_entry;
        if (bus.i_ex_upd_vld) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (bus.i_ex_taken) begin
                    wr_entry.ctr    = (ex_entry.ctr == CTR_STRONG_T) ? CTR_STRONG_T
                                                                     : ex_entry.ctr + 2'd1;
                    wr_entry.target = bus.i_ex_target[31:2];
                end else begin
                    wr_entry.ctr    = (ex_entry.ctr == CTR_STRONG_NT) ? CTR_STRONG_NT
                                                                      : ex_entry.ctr - 2'd1;
                end
            end else if (bus.i_ex_taken) begin
                // Taken miss evicts whatever aliases into this slot.
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = ex_tag;
                wr_entry.target = bus.i_ex_target[31:2];
                wr_entry.ctr    = CTR_WEAK_T;
            end
        end
    end

    // Table storage: reset clears every entry, otherwise a single write per edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the table is reset entry by entry because an unknown valid bit would produce a bogus hit after reset.
            for (int i = 0; i < DEPTH; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= CTR_WEAK_NT;
            end
        end else if (wr_en) begin
            // NOTE: state is written with <= so every register samples pre-edge values and no ordering race exists between processes.
            btb_q[ex_idx] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef BPU_PERF_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Saturating counts of resolved branches and of front-end flushes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (bus.i_ex_upd_vld) begin
            if (br_cnt_q != 32'hFFFF_FFFF) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (bus.i_ex_mispred && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign bus.o_perf_br_cnt      = br_cnt_q;
    assign bus.o_perf_mispred_cnt = mispred_cnt_q;
`else
    assign bus.o_perf_br_cnt      = 32'h0;
    assign bus.o_perf_mispred_cnt = 32'h0;
`endif

    // ------------------------------------------------------------------
    // PC bits outside index/tag and the mispredict flag (perf only) are
    // intentionally ignored.
    // ------------------------------------------------------------------
    logic unused_bits;
`ifdef BPU_PERF_EN
    assign unused_bits = ^{bus.i_if_pc[31:TAG_HI+1], bus.i_if_pc[1:0],
                           bus.i_ex_pc[31:TAG_HI+1], bus.i_ex_pc[1:0],
                           bus.i_ex_target[1:0]};
`else
    assign unused_bits = ^{bus.i_if_pc[31:TAG_HI+1], bus.i_if_pc[1:0],
                           bus.i_ex_pc[31:TAG_HI+1], bus.i_ex_pc[1:0],
                           bus.i_ex_target[1:0], bus.i_ex_mispred};
`endif

endmodule : two_bit_bpu

// File: tb/tb_two_bit_bpu.sv
// -----------------------------------------------------------------------------
// tb_two_bit_bpu
// Directed bench for two_bit_bpu with hand-computed expectations. Perf counter
// expectations follow BPU_PERF_EN (zero when the macro is undefined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_two_bit_bpu;

    logic i_clk;
    logic i_rst;

    two_bit_bpu_if bus ();

    two_bit_bpu #(
        .INDEX_W (6),
        .TAG_W   (8)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one EX update across a single rising edge, then return at edge+1.
    task automatic upd(input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic mis);
        @(negedge i_clk);
        bus.i_ex_pc      = pc;
        bus.i_ex_taken   = taken;
        bus.i_ex_target  = tgt;
        bus.i_ex_mispred = mis;
        bus.i_ex_upd_vld = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_ex_upd_vld = 1'b0;
    endtask

    // Present a fetch PC and compare all three prediction outputs.
    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] nxt);
        bus.i_if_pc = pc;
        #1;
        check({tag, ".hit"},   {31'd0, bus.o_pred_hit},   {31'd0, hit});
        check({tag, ".taken"}, {31'd0, bus.o_pred_taken}, {31'd0, taken});
        check({tag, ".next"},  bus.o_pred_next_pc,        nxt);
    endtask

    initial begin
        bus.i_if_pc      = 32'h0000_0100;
        bus.i_ex_upd_vld = 1'b0;
        bus.i_ex_pc      = 32'h0;
        bus.i_ex_taken   = 1'b0;
        bus.i_ex_target  = 32'h0;
        bus.i_ex_mispred = 1'b0;
        i_rst            = 1'b1;

        // Reset state, observed while reset is held and after release
        look("rst_hold", 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0104);
        check("rst_perf_br", bus.o_perf_br_cnt, 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);
        look("rst_100",  32'h0000_0100, 1'b0, 1'b0, 32'h0000_0104);

        // Allocate and predict
        upd(32'h0000_0040, 1'b1, 32'h0000_0010, 1'b1);
        look("alloc", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0010);

        // Hysteresis: 10 -> 01 -> 00 -> 00 -> 00
        upd(32'h0000_0040, 1'b0, 32'h0000_0BAD, 1'b1);
        look("nt1", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b0, 32'h0000_0BAD, 1'b0);
        upd(32'h0000_0040, 1'b0, 32'h0000_0BAD, 1'b0);
        upd(32'h0000_0040, 1'b0, 32'h0000_0BAD, 1'b0);
        look("nt_sat", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
        // 00 -> 01 (still not taken) -> 10 (taken again)
        upd(32'h0000_0040, 1'b1, 32'h0000_0010, 1'b1);
        look("t1", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b1, 32'h0000_0010, 1'b1);
        look("t2", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0010);
        // 10 -> 11 with new target; not-taken to 10 keeps that target
        upd(32'h0000_0040, 1'b1, 32'h0000_0020, 1'b0);
        upd(32'h0000_0040, 1'b0, 32'hDEAD_0000, 1'b0);
        look("nt_keep_tgt", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0020);

        // Aliasing: 0x140 shares index 0x10 with 0x40 but has tag 0x01
        look("alias_miss", 32'h0000_0140, 1'b0, 1'b0, 32'h0000_0144);
        upd(32'h0000_0140, 1'b1, 32'h0000_0300, 1'b1);
        look("alias_new", 32'h0000_0140, 1'b1, 1'b1, 32'h0000_0300);
        look("alias_old", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);

        // Not-taken miss never allocates
        upd(32'h0000_0080, 1'b0, 32'h0000_0500, 1'b0);
        look("nt_noalloc", 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0084);

        // Same-cycle lookup and allocation of 0x40: old result now, hit after the edge
        @(negedge i_clk);
        bus.i_if_pc      = 32'h0000_0040;
        bus.i_ex_pc      = 32'h0000_0040;
        bus.i_ex_taken   = 1'b1;
        bus.i_ex_target  = 32'h0000_0060;
        bus.i_ex_mispred = 1'b1;
        bus.i_ex_upd_vld = 1'b1;
        #1;
        check("coll_pre.hit", {31'd0, bus.o_pred_hit}, 32'd0);
        check("coll_pre.next", bus.o_pred_next_pc, 32'h0000_0044);
        @(posedge i_clk);
        #1;
        bus.i_ex_upd_vld = 1'b0;
        look("coll_post", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0060);
        look("low_bits_ignored", 32'h0000_0042, 1'b1, 1'b1, 32'h0000_0060);

        // Asynchronous reset between edges drops the hit immediately
        @(posedge i_clk);
        #2;
        bus.i_if_pc = 32'h0000_0040;
        i_rst = 1'b1;
        #1;
        check("async_rst.hit", {31'd0, bus.o_pred_hit}, 32'd0);
        check("async_rst.next", bus.o_pred_next_pc, 32'h0000_0044);

        // Update coincident with reset is dropped
        @(negedge i_clk);
        bus.i_ex_pc      = 32'h0000_0040;
        bus.i_ex_taken   = 1'b1;
        bus.i_ex_target  = 32'h0000_0070;
        bus.i_ex_mispred = 1'b1;
        bus.i_ex_upd_vld = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_ex_upd_vld = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        look("rst_drop", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
        check("rst_drop_perf_br", bus.o_perf_br_cnt, 32'h0);

        // Five updates, two of them mispredicts
        upd(32'h0000_0100, 1'b1, 32'h0000_0400, 1'b1);  // alloc, ctr 10
        upd(32'h0000_0100, 1'b1, 32'h0000_0400, 1'b0);  // ctr 11
        upd(32'h0000_0104, 1'b0, 32'h0000_0000, 1'b0);  // miss, no alloc
        upd(32'h0000_0100, 1'b0, 32'h0000_0000, 1'b1);  // ctr 10
        upd(32'h0000_0108, 1'b1, 32'h0000_0010, 1'b0);  // alloc
        look("perf_tbl_100", 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0400);
        look("perf_tbl_104", 32'h0000_0104, 1'b0, 1'b0, 32'h0000_0108);
`ifdef BPU_PERF_EN
        check("perf_br",      bus.o_perf_br_cnt,      32'd5);
        check("perf_mispred", bus.o_perf_mispred_cnt, 32'd2);
`else
        check("perf_br_off",      bus.o_perf_br_cnt,      32'd0);
        check("perf_mispred_off", bus.o_perf_mispred_cnt, 32'd0);
`endif

        // Reset clears counters and table without a clock edge
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("final_rst_perf_br",      bus.o_perf_br_cnt,      32'd0);
        check("final_rst_perf_mispred", bus.o_perf_mispred_cnt, 32'd0);
        check("final_rst.hit", {31'd0, bus.o_pred_hit}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_two_bit_bpu

// File: doc/two_bit_bpu.md
# two_bit_bpu

Branch prediction unit for the pipelined RV32I core: a direct-mapped branch target buffer whose entries each carry a 2-bit saturating direction counter. It sits directly upstream of the fetch stage. Each cycle it takes the IF-stage PC and supplies the next fetch PC. The EX stage sends resolved control-flow outcomes back to it, and it trains the table from them.

## Interface
- INDEX_W, 6: table index width; 2^INDEX_W entries.
- TAG_W, 8: stored tag width.
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_if_pc  in  32  PC currently being fetched.
- o_pred_hit  out  1  valid tag match for i_if_pc.
- o_pred_taken  out  1  predicted taken (hit and counter[1] = 1).
- o_pred_next_pc  out  32  next fetch PC: target if o_pred_taken, else i_if_pc + 4.
- i_ex_upd_vld  in  1  EX resolved a conditional branch or JAL this cycle (JALR never asserted).
- i_ex_pc  in  32  PC of the resolved instruction.
- i_ex_taken  in  1  actual direction.
- i_ex_target  in  32  actual taken target.
- i_ex_mispred  in  1  EX flushed the front end for this instruction (qualified by i_ex_upd_vld).
- o_perf_br_cnt  out  32  resolved-branch count (BPU_PERF_EN only).
- o_perf_mispred_cnt  out  32  mispredict count (BPU_PERF_EN only).

## Operation
- Index = pc[INDEX_W+1:2]; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2]; pc[1:0] ignored.
- Entry = {valid, tag, target[31:2], ctr[1:0]}.
- Counter encoding:
  - 00 strong not-taken
  - 01 weak not-taken
  - 10 weak taken
  - 11 strong taken
- Lookup is purely combinational on i_if_pc.
  - Hit = valid && tag match.
  - Miss always predicts not-taken, with next PC = i_if_pc + 4 (32-bit wrap, carry dropped).
- Update on a rising edge with i_ex_upd_vld = 1, at the index derived from i_ex_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target ← i_ex_target.
  - Hit, not taken: ctr = max(ctr−1, 0); target unchanged.
  - Miss, taken: allocate, overwriting any occupant. Valid = 1, tag from i_ex_pc, target = i_ex_target, ctr = 10.
  - Miss, not taken: no table change.
- There is no explicit invalidate path. Only reset clears entries.

## Timing
- Lookup latency 0 cycles: outputs follow i_if_pc within the same cycle.
- Update latency 1 edge: a write at edge N is visible to lookups from edge N onward (next cycle).
- Same-cycle lookup and update to the same index: lookup returns the pre-update entry. No bypass.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits clear immediately; ctr = 01, tag = 0, target = 0.
  - While reset is held and after it releases, until the first allocation: o_pred_hit = 0, o_pred_taken = 0, o_pred_next_pc = i_if_pc + 4.
  - An update coincident with reset is dropped.
  - Perf counters reset to 0.
- A single write port is sufficient, since EX resolves at most one branch per cycle.

## Configuration
- BPU_PERF_EN defined:
  - o_perf_br_cnt increments on every edge with i_ex_upd_vld = 1.
  - o_perf_mispred_cnt increments when i_ex_upd_vld && i_ex_mispred.
  - Both counters saturate at 32'hFFFF_FFFF.
- BPU_PERF_EN undefined: no counter registers; both perf outputs are tied to 32'h0.

## Test plan
- Reset then lookup: pulse i_rst, set i_if_pc = 0x0000_0100 → hit 0, taken 0, next_pc 0x0000_0104. Repeat with i_if_pc = 0xFFFF_FFFC → next_pc 0x0000_0000.
- Allocate and predict: update pc 0x0000_0040, taken, target 0x0000_0010. Next cycle lookup 0x0000_0040 → hit 1, taken 1, next_pc 0x0000_0010.
- Counter hysteresis: starting from ctr = 10 at pc 0x40, apply one not-taken → predicts not-taken (ctr 01). Apply 3 more not-taken → ctr saturates at 00. Apply 2 taken → ctr 10, predicts taken again.
- Aliasing and no-allocate:
  - With INDEX_W = 6, allocate pc 0x40; lookup 0x140 (same index, different tag) → hit 0.
  - Taken update at 0x140 replaces the entry; 0x40 then misses.
  - A not-taken miss at 0x80 leaves the table unchanged.
- Same-cycle collision: lookup 0x40 while allocating 0x40 in the same cycle → old (miss) result that cycle, hit on the next.
- Async reset mid-stream: assert i_rst between edges with the table populated → o_pred_hit falls without waiting for a clock edge. With BPU_PERF_EN, after 5 updates with 2 mispredicts → counters read 5 and 2, then 0 after reset.
